// File: rtl/pc_context_unit_pkg.sv
// Shared CPU definitions: execution-context state encoding, scheduler entry
// address and default geometry used by the PC/context unit and the control unit.
package pc_context_unit_pkg;

    typedef enum logic [1:0] {
        RUN_USER   = 2'b00,
        RUN_KERNEL = 2'b01,
        HALTED     = 2'b10
    } ctx_state_e;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_IMM_W      = 11;
    localparam int unsigned DEF_NPROC      = 4;
    localparam int unsigned DEF_QUANTUM    = 16;
    localparam int unsigned DEF_SCHED_ADDR = 0;

    // Register jumps replace only the low 26 PC bits, keeping the segment.
    localparam int unsigned JR_LOW_W = 26;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctx_pc_table.sv
// Per-process saved-PC table: one synchronous write port, one combinational
// read port, every slot cleared to the reset value.
module ctx_pc_table
    import pc_context_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NPROC     = DEF_NPROC,
    parameter int unsigned RESET_VAL = DEF_SCHED_ADDR,
    localparam int unsigned IDX_W    = idx_width(NPROC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] r_slot [NPROC];
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Indices beyond NPROC exist when NPROC is not a power of two.
    assign w_wr_ok = ({1'b0, waddr} < (IDX_W+1)'(NPROC));
    assign w_rd_ok = ({1'b0, raddr} < (IDX_W+1)'(NPROC));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NPROC; i++) begin
                r_slot[i] <= ADDR_W'(RESET_VAL);
            end
        end else if (we && w_wr_ok) begin
            r_slot[waddr] <= wdata;
        end
    end

    assign rdata = w_rd_ok ? r_slot[raddr] : ADDR_W'(RESET_VAL);

endmodule

// File: rtl/pc_context_unit.sv
// Program counter with time-sliced process contexts: user/kernel modes,
// quantum preemption into the scheduler, halt with button resume.
module pc_context_unit
    import pc_context_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned IMM_W      = DEF_IMM_W,
    parameter int unsigned NPROC      = DEF_NPROC,
    parameter int unsigned QUANTUM    = DEF_QUANTUM,
    parameter int unsigned SCHED_ADDR = DEF_SCHED_ADDR,
    localparam int unsigned PID_W     = idx_width(NPROC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    input  logic              pause,
    input  logic              botao,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              resume,
    input  logic [PID_W-1:0]  resume_pid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [PID_W-1:0]  cur_pid,
    output logic              kernel,
    output logic              halted,
    output logic              ctx_switch
);

    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);
    localparam logic [ADDR_W-1:0] SCHED_PC = ADDR_W'(SCHED_ADDR);

    ctx_state_e         r_state;
    ctx_state_e         r_ret_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [PID_W-1:0]   r_cur_pid;
    logic [CNT_W-1:0]   r_quantum;
    logic               r_kernel;
    logic               r_halted;
    logic               r_ctx_switch;
    logic               r_botao_q;

    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_next_pc;
    logic [ADDR_W-1:0]  w_slot_rd;
    logic               w_botao_rise;
    logic               w_pid_ok;
    logic               w_expire;
    logic               w_tbl_we;
    logic               w_unused_rs_hi;

    assign w_unused_rs_hi = &{1'b0, rs_val[ADDR_W-1:JR_LOW_W]};

    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_comb begin
        w_next_pc = w_pc_inc;
        if (jump_reg) begin
            w_next_pc                 = r_pc;
            w_next_pc[JR_LOW_W-1:0]   = rs_val[JR_LOW_W-1:0];
        end else if (jump || branch_taken) begin
            w_next_pc                 = r_pc;
            w_next_pc[IMM_W-1:0]      = imm;
        end
    end

    assign w_botao_rise = botao & ~r_botao_q;
    assign w_pid_ok     = ({1'b0, resume_pid} < (PID_W+1)'(NPROC));
    assign w_expire     = (r_state == RUN_USER) && (r_quantum == CNT_W'(1));
    // Pause outranks expiry, so the slot is only written on a real preemption.
    assign w_tbl_we     = step && !pause && w_expire;

    ctx_pc_table #(
        .ADDR_W    (ADDR_W),
        .NPROC     (NPROC),
        .RESET_VAL (SCHED_ADDR)
    ) u_table (
        .clock (clock),
        .reset (reset),
        .we    (w_tbl_we),
        .waddr (r_cur_pid),
        .wdata (w_next_pc),
        .raddr (resume_pid),
        .rdata (w_slot_rd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RUN_KERNEL;
            r_ret_state  <= RUN_KERNEL;
            r_pc         <= SCHED_PC;
            r_cur_pid    <= '0;
            r_quantum    <= CNT_W'(QUANTUM);
            r_kernel     <= 1'b1;
            r_halted     <= 1'b0;
            r_ctx_switch <= 1'b0;
            r_botao_q    <= 1'b0;
        end else begin
            r_botao_q    <= botao;
            r_ctx_switch <= 1'b0;
            case (r_state)
                HALTED: begin
                    if (w_botao_rise) begin
                        r_state  <= r_ret_state;
                        r_pc     <= w_pc_inc;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    if (step) begin
                        if (pause) begin
                            r_ret_state <= r_state;
                            r_state     <= HALTED;
                            r_halted    <= 1'b1;
                        end else if (w_expire) begin
                            r_pc         <= SCHED_PC;
                            r_state      <= RUN_KERNEL;
                            r_kernel     <= 1'b1;
                            r_quantum    <= '0;
                            r_ctx_switch <= 1'b1;
                        end else if (r_state == RUN_USER) begin
                            r_quantum <= r_quantum - CNT_W'(1);
                            r_pc      <= w_next_pc;
                        end else if (resume && w_pid_ok) begin
                            r_pc      <= w_slot_rd;
                            r_cur_pid <= resume_pid;
                            r_quantum <= CNT_W'(QUANTUM);
                            r_state   <= RUN_USER;
                            r_kernel  <= 1'b0;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign pc_plus1   = w_pc_inc;
    assign cur_pid    = r_cur_pid;
    assign kernel     = r_kernel;
    assign halted     = r_halted;
    assign ctx_switch = r_ctx_switch;

endmodule
